// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt capture/arbitration front end:
// request width, ID width, FSM state encoding and the ID-to-clear-vector helper.
package irq_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot_id(input logic [ID_W-1:0] id);
        onehot_id     = '0;
        onehot_id[id] = 1'b1;
    endfunction

endpackage

// File: rtl/irq_req_sync.sv
// Multi-flop synchroniser for asynchronous request lines, followed by a
// one-cycle delayed copy used to detect rising edges of the synchronised level.
module irq_req_sync
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int W           = NUM_REQ
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] req_in,
    output logic [W-1:0] req_s,
    output logic [W-1:0] rise
);

    logic [W-1:0] sync_q [SYNC_STAGES];
    logic [W-1:0] req_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            req_d <= '0;
        end else begin
            sync_q[0] <= req_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            req_d <= req_s;
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];
    assign rise  = req_s & ~req_d;

endmodule

// File: rtl/irq_capture_arbiter.sv
// Captures synchronised request edges into a sticky pending register, then
// presents the highest-index eligible request as a 2-bit ID on valid/ready.
module irq_capture_arbiter
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_in,
    input  logic [NUM_REQ-1:0] mask,
    output logic [ID_W-1:0]    out_id,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_REQ-1:0] pending,
    output logic [NUM_REQ-1:0] ovf,
    input  logic [NUM_REQ-1:0] ovf_clr
);

    logic [NUM_REQ-1:0] req_s;
    logic [NUM_REQ-1:0] rise;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] clr_vec;
    logic [ID_W-1:0]    sel_id;
    logic               fire;
    state_t             state;

    irq_req_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .W           (NUM_REQ)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_in (req_in),
        .req_s  (req_s),
        .rise   (rise)
    );

    // Handshake: out_id/out_valid are registered and held stable while
    // out_valid=1; a transfer happens on a clk edge where out_valid && out_ready.
    // out_ready is ignored while out_valid=0.
    assign fire    = (state == PRESENT) && out_ready;
    assign clr_vec = fire ? onehot_id(out_id) : '0;
    assign elig    = pending & mask;

    always_comb begin
        sel_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (elig[i]) begin
                sel_id = ID_W'(i);
            end
        end
    end

    // A new rise on the bit being serviced re-arms it rather than overflowing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            ovf     <= '0;
        end else if (EDGE_MODE != 0) begin
            pending <= (pending & ~clr_vec) | rise;
            ovf     <= (ovf & ~ovf_clr) | (rise & pending & ~clr_vec);
        end else begin
            pending <= req_s;
            ovf     <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (elig != '0) begin
                        out_id    <= sel_id;
                        out_valid <= 1'b1;
                        state     <= PRESENT;
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_capture_arbiter.sv
// Directed bench for irq_capture_arbiter: edge-mode instance for capture,
// priority, masking, overflow and reset; level-mode instance for repeat grants.
module tb_irq_capture_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_in, mask, ovf_clr, pending, ovf;
    logic [1:0] out_id;
    logic       out_valid, out_ready;

    logic [3:0] req_in_l, mask_l, ovf_clr_l, pending_l, ovf_l;
    logic [1:0] out_id_l;
    logic       out_valid_l, out_ready_l;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [1:0] exp_q[$];
    logic [1:0] exp_id;

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    irq_capture_arbiter #(.SYNC_STAGES(2), .EDGE_MODE(1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .mask      (mask),
        .out_id    (out_id),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    irq_capture_arbiter #(.SYNC_STAGES(2), .EDGE_MODE(0)) u_lvl (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in_l),
        .mask      (mask_l),
        .out_id    (out_id_l),
        .out_valid (out_valid_l),
        .out_ready (out_ready_l),
        .pending   (pending_l),
        .ovf       (ovf_l),
        .ovf_clr   (ovf_clr_l)
    );

    // driver tasks
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_in = '0; mask = 4'hF; out_ready = 1'b0; ovf_clr = '0;
        req_in_l = '0; mask_l = 4'hF; out_ready_l = 1'b0; ovf_clr_l = '0;
        tick(2);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        tests_run++; if (out_id !== 2'b00) begin tests_failed++; $display("FAIL rst_id: got %b want 00", out_id); end
        tests_run++; if (pending !== 4'b0000) begin tests_failed++; $display("FAIL rst_pending: got %b want 0000", pending); end
        tests_run++; if (ovf !== 4'b0000) begin tests_failed++; $display("FAIL rst_ovf: got %b want 0000", ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);
    endtask

    task automatic test_latency();
        mask = 4'hF; out_ready = 1'b1;
        req_in = 4'b0010;
        for (int i = 1; i <= 3; i++) begin
            tick();
            tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL lat_early edge%0d: got %b want 0", i, out_valid); end
        end
        tick();
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL lat_valid: got %b want 1", out_valid); end
        tests_run++; if (out_id !== 2'b01) begin tests_failed++; $display("FAIL lat_id: got %b want 01", out_id); end
        tests_run++; if (pending !== 4'b0010) begin tests_failed++; $display("FAIL lat_pend: got %b want 0010", pending); end
        tick();
        tests_run++; if (pending !== 4'b0000) begin tests_failed++; $display("FAIL lat_clear: got %b want 0000", pending); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL lat_drop: got %b want 0", out_valid); end
        out_ready = 1'b0; req_in = '0;
        tick(4);
    endtask

    task automatic test_priority();
        exp_q.push_back(2'b01); exp_q.push_back(2'b11); exp_q.push_back(2'b00);
        mask = 4'hF; out_ready = 1'b0;
        req_in = 4'b0011;
        tick(4);
        exp_id = exp_q.pop_front();
        tests_run++; if (out_valid !== 1'b1 || out_id !== exp_id) begin tests_failed++; $display("FAIL pri_first: got v=%b id=%b want v=1 id=%b", out_valid, out_id, exp_id); end
        req_in = 4'b1011;
        tick(5);
        tests_run++; if (out_valid !== 1'b1 || out_id !== 2'b01) begin tests_failed++; $display("FAIL pri_hold: got v=%b id=%b want v=1 id=01", out_valid, out_id); end
        tests_run++; if (pending !== 4'b1011) begin tests_failed++; $display("FAIL pri_pend: got %b want 1011", pending); end
        out_ready = 1'b1;
        tick();
        tests_run++; if (pending !== 4'b1001) begin tests_failed++; $display("FAIL pri_acc1: got %b want 1001", pending); end
        tick();
        exp_id = exp_q.pop_front();
        tests_run++; if (out_valid !== 1'b1 || out_id !== exp_id) begin tests_failed++; $display("FAIL pri_second: got v=%b id=%b want v=1 id=%b", out_valid, out_id, exp_id); end
        tick(2);
        exp_id = exp_q.pop_front();
        tests_run++; if (out_valid !== 1'b1 || out_id !== exp_id) begin tests_failed++; $display("FAIL pri_third: got v=%b id=%b want v=1 id=%b", out_valid, out_id, exp_id); end
        tick();
        tests_run++; if (pending !== 4'b0000) begin tests_failed++; $display("FAIL pri_empty: got %b want 0000", pending); end
        out_ready = 1'b0; req_in = '0;
        tick(4);
    endtask

    task automatic test_mask();
        out_ready = 1'b0; mask = 4'b0001;
        req_in = 4'b1001;
        tick(4);
        tests_run++; if (pending !== 4'b1001) begin tests_failed++; $display("FAIL msk_pend: got %b want 1001", pending); end
        tests_run++; if (out_valid !== 1'b1 || out_id !== 2'b00) begin tests_failed++; $display("FAIL msk_first: got v=%b id=%b want v=1 id=00", out_valid, out_id); end
        out_ready = 1'b1; mask = 4'hF;
        tick();
        tests_run++; if (pending !== 4'b1000) begin tests_failed++; $display("FAIL msk_acc: got %b want 1000", pending); end
        tick();
        tests_run++; if (out_valid !== 1'b1 || out_id !== 2'b11) begin tests_failed++; $display("FAIL msk_second: got v=%b id=%b want v=1 id=11", out_valid, out_id); end
        tick();
        out_ready = 1'b0; req_in = '0;
        tick(4);
        tests_run++; if (pending !== 4'b0000) begin tests_failed++; $display("FAIL msk_empty: got %b want 0000", pending); end
    endtask

    task automatic test_overflow();
        mask = 4'hF; out_ready = 1'b0;
        req_in = 4'b0100;
        tick(4);
        tests_run++; if (out_valid !== 1'b1 || out_id !== 2'b10) begin tests_failed++; $display("FAIL ovf_grant: got v=%b id=%b want v=1 id=10", out_valid, out_id); end
        req_in = '0; tick(3);
        req_in = 4'b0100; tick(4);
        tests_run++; if (ovf !== 4'b0100) begin tests_failed++; $display("FAIL ovf_set: got %b want 0100", ovf); end
        tests_run++; if (pending !== 4'b0100) begin tests_failed++; $display("FAIL ovf_pend: got %b want 0100", pending); end
        ovf_clr = 4'b0100; tick(); ovf_clr = '0;
        tests_run++; if (ovf !== 4'b0000) begin tests_failed++; $display("FAIL ovf_clr: got %b want 0000", ovf); end
        // set and clear on the same edge
        req_in = '0; tick(3);
        req_in = 4'b0100; tick(2);
        ovf_clr = 4'b0100; tick(); ovf_clr = '0;
        tests_run++; if (ovf !== 4'b0100) begin tests_failed++; $display("FAIL ovf_setwins: got %b want 0100", ovf); end
        ovf_clr = 4'hF; tick(); ovf_clr = '0;
        // rise coincident with acceptance of the same bit
        req_in = '0; tick(3);
        req_in = 4'b0100; tick(2);
        out_ready = 1'b1; tick();
        tests_run++; if (pending !== 4'b0100) begin tests_failed++; $display("FAIL rise_wins_pend: got %b want 0100", pending); end
        tests_run++; if (ovf !== 4'b0000) begin tests_failed++; $display("FAIL rise_wins_ovf: got %b want 0000", ovf); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rise_wins_drop: got %b want 0", out_valid); end
        tick();
        tests_run++; if (out_valid !== 1'b1 || out_id !== 2'b10) begin tests_failed++; $display("FAIL rise_wins_regrant: got v=%b id=%b want v=1 id=10", out_valid, out_id); end
        tick();
        tests_run++; if (pending !== 4'b0000) begin tests_failed++; $display("FAIL rise_wins_done: got %b want 0000", pending); end
        out_ready = 1'b0; req_in = '0;
        tick(4);
    endtask

    task automatic test_reset_midop();
        mask = 4'hF; out_ready = 1'b0;
        req_in = 4'b0100;
        tick(4);
        tests_run++; if (out_valid !== 1'b1 || out_id !== 2'b10) begin tests_failed++; $display("FAIL mrst_pre: got v=%b id=%b want v=1 id=10", out_valid, out_id); end
        #2;
        rst_n = 1'b0; req_in = '0;
        #1;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL mrst_valid: got %b want 0", out_valid); end
        tests_run++; if (out_id !== 2'b00) begin tests_failed++; $display("FAIL mrst_id: got %b want 00", out_id); end
        tests_run++; if (pending !== 4'b0000) begin tests_failed++; $display("FAIL mrst_pend: got %b want 0000", pending); end
        tests_run++; if (ovf !== 4'b0000) begin tests_failed++; $display("FAIL mrst_ovf: got %b want 0000", ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        tick(6);
        tests_run++; if (out_valid !== 1'b0 || pending !== 4'b0000) begin tests_failed++; $display("FAIL mrst_stale: got v=%b p=%b want v=0 p=0000", out_valid, pending); end
    endtask

    task automatic test_level();
        mask_l = 4'hF; out_ready_l = 1'b1;
        req_in_l = 4'b0100;
        tick(3);
        tests_run++; if (out_valid_l !== 1'b0) begin tests_failed++; $display("FAIL lvl_early: got %b want 0", out_valid_l); end
        for (int g = 0; g < 3; g++) begin
            tick();
            tests_run++; if (out_valid_l !== 1'b1 || out_id_l !== 2'b10) begin tests_failed++; $display("FAIL lvl_grant%0d: got v=%b id=%b want v=1 id=10", g, out_valid_l, out_id_l); end
            tests_run++; if (pending_l !== 4'b0100) begin tests_failed++; $display("FAIL lvl_pend%0d: got %b want 0100", g, pending_l); end
            tick();
            tests_run++; if (out_valid_l !== 1'b0) begin tests_failed++; $display("FAIL lvl_bubble%0d: got %b want 0", g, out_valid_l); end
        end
        tests_run++; if (ovf_l !== 4'b0000) begin tests_failed++; $display("FAIL lvl_ovf: got %b want 0000", ovf_l); end
        req_in_l = '0;
        tick(6);
        for (int i = 0; i < 6; i++) begin
            tests_run++; if (out_valid_l !== 1'b0) begin tests_failed++; $display("FAIL lvl_quiet%0d: got %b want 0", i, out_valid_l); end
            tick();
        end
        tests_run++; if (pending_l !== 4'b0000) begin tests_failed++; $display("FAIL lvl_empty: got %b want 0000", pending_l); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_priority();
        test_mask();
        test_overflow();
        test_reset_midop();
        test_level();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
